uart_rx_buffer: RTL
===================

// Module: uart_rx_buffer
// PURPOSE
//  Memory-mapped receive stage downstream of the uart core. Captures each byte
//  flagged by the uart rdy/dout pair and acknowledges it via rdy_clr.
//  Buffers bytes in a FIFO and exposes data and status words to the Processor
//  on the 32-bit read bus.
//  Sits beside the TX Controller in TopLevel, selected by the ctrl_access decode.
// PARAMETERS
//  DEPTH   16  FIFO entries; must be a power of two, 2..256
//  ADDR_W  4   log2(DEPTH); FIFO pointer width
// PORTS
//  Clock       input   1   system clock (clock_25MHz domain)
//  Reset       input   1   asynchronous, active-low reset
//  Rx_Ready    input   1   uart rdy: level, held high until Rx_Clear is pulsed
//  Rx_Data     input   8   uart dout: valid while Rx_Ready=1
//  Rx_Clear    output  1   uart rdy_clr: one-cycle acknowledge pulse
//  Reg_Sel     input   1   0 = DATA word, 1 = STATUS word (CPU address bit 2)
//  Read_Pop    input   1   CPU read strobe on DATA; pops head at Clock edge
//  Clear_Err   input   1   CPU write strobe; clears sticky overrun
//  Data_Out    output  32  read-bus word (combinational from registered state)
//  Rx_Irq      output  1   high while FIFO not empty
// BEHAVIOUR
//  Reset (async, Reset=0): FIFO empty; count=0; overrun=0; FSM=IDLE.
//   Rx_Clear=0, Rx_Irq=0, Data_Out=0 (Reg_Sel=0) or 0x0000_0000 status.
//  Capture FSM:
//   IDLE    : Rx_Ready=1 -> CAPTURE.
//   CAPTURE : if not full, push Rx_Data. If full, drop the byte and set
//             overrun=1. Always -> CLEAR.
//   CLEAR   : Rx_Clear=1 for exactly this cycle -> WAIT.
//   WAIT    : Rx_Ready=0 -> IDLE; otherwise stay.
//             Guards against re-capturing the same byte.
//  Latency: byte is visible in Data_Out/count 2 edges after Rx_Ready rises.
//   Rx_Clear pulses on the 2nd cycle.
//  DATA word:
//   {24'b0, head byte}.
//   {32'b0} when empty.
//  STATUS word:
//   bit0 = not_empty, bit1 = full, bit2 = overrun.
//   bits[8+ADDR_W:8] = count (0..DEPTH).
//   All other bits 0.
//  Pop: Read_Pop=1 & Reg_Sel=0 & not empty -> rd_ptr++, count-- at the edge.
//   Pop when empty: ignored, no state change.
//   Read_Pop with Reg_Sel=1: ignored.
//  Simultaneous push and pop in one cycle: both take effect; count unchanged.
//   Pop at count=DEPTH frees a slot, but a push on the same edge still sees
//   full and drops the byte (full is evaluated before pop).
//  Pointers are ADDR_W bits and wrap DEPTH-1 -> 0.
//   count is ADDR_W+1 bits, saturating range 0..DEPTH.
//  Overrun is sticky.
//   Clear_Err=1 clears it; a set on the same edge wins (stays 1).
//  Reset mid-operation: all state returns to reset values immediately.
//   A byte still held by the uart is captured after release (FSM restarts in IDLE).
//  Rx_Irq = not_empty, registered with the count.
// STRUCTURE
//  uart_rx_pkg: FSM state encoding (IDLE/CAPTURE/CLEAR/WAIT, 2 bits),
//   STATUS bit positions, DATA/STATUS select constants.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH, ADDR_W): register-array FIFO.
//   Has push/pop/full/empty/count; reusable for a later TX buffer.
//  Top of block: capture FSM, overrun flag, read-bus mux.
// TESTING
//  1 Reset, send 0x41 -> Rx_Clear one pulse 2 cycles later; STATUS=0x0000_0101;
//    DATA=0x0000_0041.
//  2 Send 0x10..0x1F (16 bytes), pop all 16 -> FIFO full after 16th
//    (STATUS=0x0000_1003); pops return 0x10..0x1F in order; ends empty.
//  3 Fill 16, send 0x99 -> byte dropped, overrun=1 (STATUS=0x0000_1007);
//    Rx_Clear still pulses.
//  4 Count=5; push and pop on same edge -> count stays 5; head advances.
//  5 Pop on empty FIFO -> no change, DATA=0; Clear_Err with no new overrun -> bit2=0.
//  6 Assert Reset during CLEAR with 3 bytes queued -> Rx_Clear drops at once;
//    STATUS=0. Byte still held by the uart is captured after release.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module : uart_rx_pkg
//  Brief  : Shared types and constants for the UART receive buffer: capture
//           FSM encoding, STATUS word bit positions, register select values
//           and a helper that assembles the STATUS word.
//  Rev    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

   // Capture FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_CLEAR   = 2'd2,
      ST_WAIT    = 2'd3
   } rx_state_e;

   // STATUS word bit positions
   localparam int unsigned C_STAT_NOT_EMPTY = 0;
   localparam int unsigned C_STAT_FULL      = 1;
   localparam int unsigned C_STAT_OVERRUN   = 2;
   localparam int unsigned C_STAT_COUNT_LSB = 8;

   // Reg_Sel decode (CPU address bit 2)
   localparam logic C_SEL_DATA   = 1'b0;
   localparam logic C_SEL_STATUS = 1'b1;

   // Assemble the STATUS word; count arrives zero-extended to 24 bits
   function automatic logic [31:0] pack_status(
      input logic        not_empty,
      input logic        full,
      input logic        overrun,
      input logic [23:0] count
   );
      logic [31:0] s;
      s                        = '0;
      s[C_STAT_NOT_EMPTY]      = not_empty;
      s[C_STAT_FULL]           = full;
      s[C_STAT_OVERRUN]        = overrun;
      s[31:C_STAT_COUNT_LSB]   = count;
      return s;
   endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module : sync_fifo
//  Brief  : Single-clock register-array FIFO with push/pop, full/empty flags
//           and an occupancy count. Push into a full FIFO and pop from an
//           empty FIFO are ignored. Full/empty are evaluated on the current
//           count, so a pop on a full FIFO does not admit a same-edge push.
//  Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,   // power of two, 2..256
   parameter int ADDR_W = 4     // log2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              push_en;
   logic              pop_en;

   assign full_o  = (count_q == C_DEPTH);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i  & ~empty_o;

   // Next pointers and count; pointers wrap naturally at DEPTH-1 -> 0
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module : uart_rx_buffer
//  Brief  : Memory-mapped receive stage behind the uart core. A capture FSM
//           takes each byte flagged by Rx_Ready, acknowledges it with a
//           one-cycle Rx_Clear, and queues it in a FIFO. The CPU reads the
//           head byte (DATA) or a STATUS word and pops with Read_Pop.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_rx_buffer
   import uart_rx_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic        Clock,
   input  logic        Reset,       // asynchronous, active-low
   input  logic        Rx_Ready,
   input  logic [7:0]  Rx_Data,
   output logic        Rx_Clear,
   input  logic        Reg_Sel,
   input  logic        Read_Pop,
   input  logic        Clear_Err,
   output logic [31:0] Data_Out,
   output logic        Rx_Irq
);

   rx_state_e         state_q, state_d;
   logic              overrun_q, overrun_d;
   logic              push;
   logic              pop;
   logic              overrun_set;
   logic [7:0]        fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W:0]   fifo_count;
   logic [31:0]       status_word;
   logic [31:0]       data_word;

   sync_fifo #(
      .WIDTH  (8),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (Clock),
      .rst_n   (Reset),
      .push_i  (push),
      .wdata_i (Rx_Data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Capture FSM: next state, FIFO push, overrun detection and acknowledge
   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      overrun_set = 1'b0;
      Rx_Clear    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Rx_Ready) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // FIFO drops the byte itself when full; flag it as overrun here
            push        = 1'b1;
            overrun_set = fifo_full;
            state_d     = ST_CLEAR;
         end
         ST_CLEAR: begin
            Rx_Clear = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // Hold until the uart has withdrawn rdy so one byte is taken once
            if (!Rx_Ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky overrun: a new overrun outranks a simultaneous clear request
   always_comb begin
      overrun_d = overrun_set | (overrun_q & ~Clear_Err);
   end

   // FSM state and overrun flag registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   // Pops only count when the DATA word is addressed
   assign pop    = Read_Pop & (Reg_Sel == C_SEL_DATA);
   assign Rx_Irq = ~fifo_empty;

   // Read-bus mux: head byte (zero when empty) or STATUS word
   always_comb begin
      status_word = pack_status(~fifo_empty, fifo_full, overrun_q, 24'(fifo_count));
      data_word   = fifo_empty ? 32'h0 : {24'h0, fifo_rdata};
      Data_Out    = (Reg_Sel == C_SEL_STATUS) ? status_word : data_word;
   end

endmodule : uart_rx_buffer
`default_nettype wire
